// File: rtl/ldtu_enc_pkg.sv
// ---------------------------------------------------------------------------
// ldtu_enc_pkg
// Shared definitions for the LDTU sample encoder: word/sample widths, word
// header codes, the packer state encoding, and a helper that assembles a
// partial-baseline word.
// ---------------------------------------------------------------------------
package ldtu_enc_pkg;

    localparam int WORD_W   = 32;  // output word width
    localparam int SAMPLE_W = 13;  // gain bit + 12-bit sample
    localparam int BASE_W   = 6;   // encoded width of a baseline sample

    localparam logic [1:0] HDR_BASE_FULL = 2'b01;
    localparam logic [1:0] HDR_BASE_PART = 2'b10;
    localparam logic [5:0] HDR_SIG_FULL  = 6'b001010;
    localparam logic [5:0] HDR_SIG_PART  = 6'b001011;
    localparam logic [3:0] HDR_TRAILER   = 4'b1111;

    // Packer state. BASE additionally carries a held-sample count (1..4).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BASE = 2'd1,
        ST_SIG  = 2'd2
    } enc_state_e;

    // Partial baseline word: header, 3 zero bits, count, then up to four
    // 6-bit samples with the oldest in the LSBs (unused slots already zero).
    function automatic logic [WORD_W-1:0] base_part_word(
        input logic [2:0]  n,
        input logic [23:0] samples
    );
        return {HDR_BASE_PART, 3'b000, n, samples};
    endfunction

endpackage

// File: rtl/ldtu_enc_ofifo.sv
// ---------------------------------------------------------------------------
// ldtu_enc_ofifo
// Synchronous show-ahead FIFO with an occupancy counter and a sticky
// overflow flag. The head entry is presented on head/valid without a read
// request; pop consumes it on the next clock edge.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset (pointers, count, overflow)
//   push       write push_data this cycle
//   push_data  word to write
//   pop        consume the head word (ignored while empty)
//   head       head word, 0 while empty
//   valid      FIFO not empty
//   overflow   sticky; set when a push is dropped because the FIFO is full
// ---------------------------------------------------------------------------
module ldtu_enc_ofifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             empty, full, do_push, do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == FULL_COUNT);
        do_pop  = pop & ~empty;
        // A full FIFO still accepts a push when the head leaves the same cycle.
        do_push = push & (~full | do_pop);

        wr_ptr_d   = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        overflow_d = overflow_q | (push & ~do_push);

        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; stale contents are masked by the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head     = empty ? '0 : mem_q[rd_ptr_q];
    assign valid    = ~empty;
    assign overflow = overflow_q;

endmodule

// File: rtl/ldtu_sample_encoder.sv
// ---------------------------------------------------------------------------
// ldtu_sample_encoder
// Packs a stream of 13-bit samples into 32-bit words: runs of baseline
// samples become 6-bit-per-sample words (5 per full word), signal samples
// become 13-bit-per-sample words (2 per full word). Completed words go into
// a show-ahead output FIFO drained with a valid/ready handshake.
//
// Ports:
//   CLK             system clock
//   reset           asynchronous active-low reset; 0 clears all state
//   ENC_enable      sample on DATA_to_enc is accepted this cycle
//   DATA_to_enc     [12] gain bit, [11:0] sample
//   baseline_flag   sample is baseline (only [5:0] encoded)
//   flush           emit the partial word (when no sample is accepted)
//   DATA_out        head word of the output FIFO (0 when empty)
//   out_valid       DATA_out valid
//   out_ready       consumer pops the head when out_valid & out_ready
//   ofifo_overflow  sticky; a push was dropped
//
// Build option: define LDTU_ENC_FRAME_TRAILER_EN to append a trailer word
// {4'b1111, 12'b0, frame number} after every FRAME_WORDS data words.
// ---------------------------------------------------------------------------
module ldtu_sample_encoder
    import ldtu_enc_pkg::*;
#(
    parameter int OFIFO_DEPTH = 8,
    parameter int FRAME_WORDS = 16
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        ENC_enable,
    input  logic [12:0] DATA_to_enc,
    input  logic        baseline_flag,
    input  logic        flush,
    output logic [31:0] DATA_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ofifo_overflow
);

    enc_state_e            state_q, state_d;
    logic [2:0]            n_q, n_d;            // baseline samples held (BASE)
    logic [23:0]           base_buf_q, base_buf_d;
    logic [SAMPLE_W-1:0]   sig_buf_q, sig_buf_d;

    logic                  data_push;
    logic [WORD_W-1:0]     data_word;
    logic                  fifo_push;
    logic [WORD_W-1:0]     fifo_word;
    logic [BASE_W-1:0]     base_smp;

    assign base_smp = DATA_to_enc[BASE_W-1:0];

    // ------------------------------------------------------------------
    // Packer. Every transition pushes at most one data word.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        base_buf_d = base_buf_q;
        sig_buf_d  = sig_buf_q;
        data_push  = 1'b0;
        data_word  = '0;

        if (ENC_enable) begin
            if (baseline_flag) begin
                case (state_q)
                    ST_IDLE: begin
                        state_d    = ST_BASE;
                        n_d        = 3'd1;
                        base_buf_d = {18'b0, base_smp};
                    end
                    ST_BASE: begin
                        if (n_q == 3'd4) begin
                            data_push  = 1'b1;
                            data_word  = {HDR_BASE_FULL, base_smp, base_buf_q};
                            state_d    = ST_IDLE;
                            n_d        = 3'd0;
                            base_buf_d = '0;
                        end else begin
                            n_d = n_q + 3'd1;
                            case (n_q)
                                3'd1:    base_buf_d[11:6]  = base_smp;
                                3'd2:    base_buf_d[17:12] = base_smp;
                                default: base_buf_d[23:18] = base_smp;
                            endcase
                        end
                    end
                    ST_SIG: begin
                        data_push  = 1'b1;
                        data_word  = {HDR_SIG_PART, 13'b0, sig_buf_q};
                        state_d    = ST_BASE;
                        n_d        = 3'd1;
                        base_buf_d = {18'b0, base_smp};
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d   = ST_SIG;
                        sig_buf_d = DATA_to_enc;
                    end
                    ST_SIG: begin
                        data_push = 1'b1;
                        data_word = {HDR_SIG_FULL, DATA_to_enc, sig_buf_q};
                        state_d   = ST_IDLE;
                    end
                    ST_BASE: begin
                        data_push  = 1'b1;
                        data_word  = base_part_word(n_q, base_buf_q);
                        state_d    = ST_SIG;
                        n_d        = 3'd0;
                        base_buf_d = '0;
                        sig_buf_d  = DATA_to_enc;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end else if (flush) begin
            // A flush coinciding with an accepted sample is ignored above;
            // the partial word then waits for a later flush.
            case (state_q)
                ST_BASE: begin
                    data_push  = 1'b1;
                    data_word  = base_part_word(n_q, base_buf_q);
                    state_d    = ST_IDLE;
                    n_d        = 3'd0;
                    base_buf_d = '0;
                end
                ST_SIG: begin
                    data_push = 1'b1;
                    data_word = {HDR_SIG_PART, 13'b0, sig_buf_q};
                    state_d   = ST_IDLE;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            n_q        <= 3'd0;
            base_buf_q <= '0;
            sig_buf_q  <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            base_buf_q <= base_buf_d;
            sig_buf_q  <= sig_buf_d;
        end
    end

`ifdef LDTU_ENC_FRAME_TRAILER_EN
    // ------------------------------------------------------------------
    // Frame trailer: counts data pushes, queues a trailer after every
    // FRAME_WORDS of them and slots it into the first cycle without a
    // data push.
    // ------------------------------------------------------------------
    localparam int CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             trailer_pend_q, trailer_pend_d;
    logic [15:0]      frame_num_q, frame_num_d;
    logic             trailer_push;

    always_comb begin
        word_cnt_d     = word_cnt_q;
        trailer_pend_d = trailer_pend_q;
        frame_num_d    = frame_num_q;
        trailer_push   = 1'b0;

        if (trailer_pend_q && !data_push) begin
            trailer_push   = 1'b1;
            trailer_pend_d = 1'b0;
            frame_num_d    = frame_num_q + 16'd1;
        end

        if (data_push) begin
            if (word_cnt_q == CNT_LAST) begin
                word_cnt_d     = '0;
                trailer_pend_d = 1'b1;
            end else begin
                word_cnt_d = word_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            word_cnt_q     <= '0;
            trailer_pend_q <= 1'b0;
            frame_num_q    <= 16'd0;
        end else begin
            word_cnt_q     <= word_cnt_d;
            trailer_pend_q <= trailer_pend_d;
            frame_num_q    <= frame_num_d;
        end
    end

    assign fifo_push = data_push | trailer_push;
    assign fifo_word = data_push ? data_word
                                 : {HDR_TRAILER, 12'b0, frame_num_q};
`else
    // Without the trailer, FRAME_WORDS only has to be a sensible value;
    // this empty block exists solely when it is not.
    if (FRAME_WORDS < 1) begin : g_frame_words_unused
    end

    assign fifo_push = data_push;
    assign fifo_word = data_word;
`endif

    ldtu_enc_ofifo #(
        .DEPTH (OFIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_ofifo (
        .clk       (CLK),
        .rst_n     (reset),
        .push      (fifo_push),
        .push_data (fifo_word),
        .pop       (out_ready),
        .head      (DATA_out),
        .valid     (out_valid),
        .overflow  (ofifo_overflow)
    );

endmodule

// File: tb/tb_ldtu_sample_encoder.sv
module tb_ldtu_sample_encoder;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        ENC_enable = 1'b0;
    logic [12:0] DATA_to_enc = '0;
    logic        baseline_flag = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] DATA_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        ofifo_overflow;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    ldtu_sample_encoder #(
        .OFIFO_DEPTH (8),
        .FRAME_WORDS (2)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .ENC_enable     (ENC_enable),
        .DATA_to_enc    (DATA_to_enc),
        .baseline_flag  (baseline_flag),
        .flush          (flush),
        .DATA_out       (DATA_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .ofifo_overflow (ofifo_overflow)
    );

    // One clock of stimulus; returns 1 time unit after the edge.
    task automatic drive(input logic en, input logic [12:0] d, input logic bl, input logic fl);
        ENC_enable    = en;
        DATA_to_enc   = d;
        baseline_flag = bl;
        flush         = fl;
        @(posedge CLK); #1;
        ENC_enable = 1'b0;
        flush      = 1'b0;
    endtask

    function automatic logic [31:0] sig_full(input logic [12:0] older, input logic [12:0] newer);
        return {6'b001010, newer, older};
    endfunction

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (DATA_out !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", DATA_out, 32'h0); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++;
        if (ofifo_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", ofifo_overflow); end
        reset = 1'b1;
        @(posedge CLK); #1;
        $display("test_reset done");
    endtask

    task automatic test_base_full;
        int guard;
        logic [31:0] e;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) drive(1'b1, 13'(i), 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL base_full_early got=%b exp=0", out_valid); end
        drive(1'b1, 13'h005, 1'b1, 1'b0);
        exp_q.push_back(32'h4510_3081);
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (DATA_out !== e) begin failures++; $display("FAIL base_full_word got=%h exp=%h", DATA_out, e); end
                else $display("base_full word %h", DATA_out);
            end
            @(posedge CLK); #1; guard++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL base_full_drain got=%0d/%b exp=0/0", exp_q.size(), out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_sig_full;
        int guard;
        logic [31:0] e;
        drive(1'b1, 13'h1ABC, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL sig_single got=%b exp=0", out_valid); end
        drive(1'b1, 13'h0123, 1'b0, 1'b0);
        exp_q.push_back(32'h2824_7ABC);
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (DATA_out !== e) begin failures++; $display("FAIL sig_full_word got=%h exp=%h", DATA_out, e); end
                else $display("sig_full word %h", DATA_out);
            end
            @(posedge CLK); #1; guard++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL sig_full_drain got=%0d/%b exp=0/0", exp_q.size(), out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_base_part_flush;
        int guard;
        logic [31:0] e;
        drive(1'b1, 13'h03F, 1'b1, 1'b0);
        drive(1'b1, 13'h000, 1'b1, 1'b0);
        drive(1'b1, 13'h015, 1'b1, 1'b0);
        drive(1'b1, 13'h0FFF, 1'b0, 1'b0);
        exp_q.push_back(32'h8301_503F);
        drive(1'b0, 13'h0, 1'b0, 1'b1);
        exp_q.push_back(32'h2C00_0FFF);
        // Flush in IDLE must not produce a word.
        drive(1'b0, 13'h0, 1'b0, 1'b1);
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (DATA_out !== e) begin failures++; $display("FAIL part_flush_word got=%h exp=%h", DATA_out, e); end
                else $display("part/flush word %h", DATA_out);
            end
            @(posedge CLK); #1; guard++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL part_flush_drain got=%0d/%b exp=0/0", exp_q.size(), out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_enable_low;
        int guard;
        logic [31:0] e;
        drive(1'b1, 13'h02A, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 13'h011, 1'b1, 1'b0);
        drive(1'b0, 13'h1234, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL enable_low_hold got=%b exp=0", out_valid); end
        for (int i = 1; i <= 4; i++) drive(1'b1, 13'(i), 1'b1, 1'b0);
        exp_q.push_back({2'b01, 6'h04, 6'h03, 6'h02, 6'h01, 6'h2A});
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (DATA_out !== e) begin failures++; $display("FAIL enable_low_word got=%h exp=%h", DATA_out, e); end
                else $display("enable_low word %h", DATA_out);
            end
            @(posedge CLK); #1; guard++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL enable_low_drain got=%0d/%b exp=0/0", exp_q.size(), out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop;
        int guard;
        logic [31:0] e;
        logic [12:0] a, b;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = 13'h0200 + 13'(2 * i);
            b = a + 13'd1;
            drive(1'b1, a, 1'b0, 1'b0);
            drive(1'b1, b, 1'b0, 1'b0);
            exp_q.push_back(sig_full(a, b));
        end
        drive(1'b1, 13'h1555, 1'b0, 1'b0);
        // FIFO is full: pop the head and push the next word on the same edge.
        out_ready = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (DATA_out !== e || out_valid !== 1'b1) begin
            failures++; $display("FAIL full_head got=%h/%b exp=%h/1", DATA_out, out_valid, e);
        end
        drive(1'b1, 13'h0AAA, 1'b0, 1'b0);
        exp_q.push_back(sig_full(13'h1555, 13'h0AAA));
        checks++;
        if (ofifo_overflow !== 1'b0) begin failures++; $display("FAIL full_push_pop_overflow got=%b exp=0", ofifo_overflow); end
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (DATA_out !== e) begin failures++; $display("FAIL full_push_pop_word got=%h exp=%h", DATA_out, e); end
                else $display("full push/pop word %h", DATA_out);
            end
            @(posedge CLK); #1; guard++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL full_push_pop_drain got=%0d/%b exp=0/0", exp_q.size(), out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow;
        int guard;
        logic [31:0] e;
        logic [12:0] a, b;
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            a = 13'h0100 + 13'(2 * i);
            b = a + 13'd1;
            drive(1'b1, a, 1'b0, 1'b0);
            drive(1'b1, b, 1'b0, 1'b0);
            if (i < 8) exp_q.push_back(sig_full(a, b));
        end
        checks++;
        if (ofifo_overflow !== 1'b1) begin failures++; $display("FAIL overflow_flag got=%b exp=1", ofifo_overflow); end
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (DATA_out !== e) begin failures++; $display("FAIL overflow_word got=%h exp=%h", DATA_out, e); end
                else $display("overflow drain word %h", DATA_out);
            end
            @(posedge CLK); #1; guard++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL overflow_drain got=%0d/%b exp=0/0", exp_q.size(), out_valid);
        end
        checks++;
        if (ofifo_overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b exp=1", ofifo_overflow); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int guard;
        logic [31:0] e;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 13'h0700 + 13'(i), 1'b0, 1'b0);
            drive(1'b1, 13'h0800 + 13'(i), 1'b0, 1'b0);
        end
        drive(1'b1, 13'h033, 1'b1, 1'b0);
        drive(1'b1, 13'h034, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL reset_mid_queued got=%b exp=1", out_valid); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || DATA_out !== 32'h0) begin
            failures++; $display("FAIL reset_mid_async got=%b/%h exp=0/00000000", out_valid, DATA_out);
        end
        checks++;
        if (ofifo_overflow !== 1'b0) begin failures++; $display("FAIL reset_mid_overflow got=%b exp=0", ofifo_overflow); end
        @(posedge CLK); #1;
        reset = 1'b1;
        @(posedge CLK); #1;
        for (int i = 0; i < 5; i++) drive(1'b1, 13'h010 + 13'(i), 1'b1, 1'b0);
        exp_q.push_back({2'b01, 6'h14, 6'h13, 6'h12, 6'h11, 6'h10});
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (DATA_out !== e) begin failures++; $display("FAIL reset_mid_word got=%h exp=%h", DATA_out, e); end
                else $display("post-reset word %h", DATA_out);
            end
            @(posedge CLK); #1; guard++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_mid_drain got=%0d/%b exp=0/0", exp_q.size(), out_valid);
        end
        out_ready = 1'b0;
    endtask

`ifdef LDTU_ENC_FRAME_TRAILER_EN
    task automatic test_trailer;
        int guard;
        logic [31:0] e;
        logic [12:0] a, b;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 13'h0400 + 13'(2 * i);
            b = a + 13'd1;
            drive(1'b1, a, 1'b0, 1'b0);
            drive(1'b1, b, 1'b0, 1'b0);
            exp_q.push_back(sig_full(a, b));
            if (i == 1) exp_q.push_back(32'hF000_0000);
            if (i == 3) exp_q.push_back(32'hF000_0001);
        end
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (DATA_out !== e) begin failures++; $display("FAIL trailer_word got=%h exp=%h", DATA_out, e); end
                else $display("trailer seq word %h", DATA_out);
            end
            @(posedge CLK); #1; guard++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL trailer_drain got=%0d/%b exp=0/0", exp_q.size(), out_valid);
        end
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifdef LDTU_ENC_FRAME_TRAILER_EN
        test_trailer();
`else
        test_base_full();
        test_sig_full();
        test_base_part_flush();
        test_enable_low();
        test_full_push_pop();
        test_overflow();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
